// File: rtl/register_11bit_pkg.sv
// Shared constants for the parallel-load register.
package register_11bit_pkg;
  localparam int REG_WIDTH_DEFAULT = 11;
endpackage

// File: rtl/register_11bit_if.sv
// Load-strobe / data bus of the register; master drives the strobe, slave owns the stored value.
interface register_11bit_if
  import register_11bit_pkg::*;
#(
  parameter int WIDTH = REG_WIDTH_DEFAULT
) ();
  logic             enable;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;

  modport master (output enable, output data_in, input  data_out);
  modport slave  (input  enable, input  data_in, output data_out);
endinterface

// File: rtl/register_11bit_reg_bit_cell.sv
// One storage bit: hold/load mux in front of an async-reset D flip-flop.
module reg_bit_cell (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic d_i,
  output logic q_o
);
  logic d_d;
  logic q_q;

  // enable only steers the mux; the flop is clocked every edge
  assign d_d = en_i ? d_i : q_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= 1'b0;
    else     q_q <= d_d;
  end

  assign q_o = q_q;
endmodule

// File: rtl/register_11bit.sv
// Parameterised parallel-load register built from identical independent bit cells.
module register_11bit
  import register_11bit_pkg::*;
#(
  parameter int WIDTH = REG_WIDTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  register_11bit_if.slave   bus
);
  logic [WIDTH-1:0] q;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    reg_bit_cell u_cell (
      .clk  (clk),
      .rst  (rst),
      .en_i (bus.enable),
      .d_i  (bus.data_in[g]),
      .q_o  (q[g])
    );
  end

  assign bus.data_out = q;
endmodule

// File: tb/tb_register_11bit.sv
// Directed checks of the load register at the default width and at WIDTH=1.
module tb_register_11bit;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  register_11bit_if #(.WIDTH(11)) bus11 ();
  register_11bit_if #(.WIDTH(1))  bus1 ();

  register_11bit #(.WIDTH(11)) dut11 (.clk(clk), .rst(rst), .bus(bus11.slave));
  register_11bit #(.WIDTH(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // advance one rising edge, then settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;

    // reset with unknown strobe; narrow instance sees load request under reset
    rst           = 1'b1;
    bus11.enable  = 1'bx;
    bus11.data_in = 11'h000;
    bus1.enable   = 1'b1;
    bus1.data_in  = 1'b1;
    #1;
    chk("rst_async", {21'd0, bus11.data_out}, 32'h000);
    chk("rst_async_w1", {31'd0, bus1.data_out}, 32'h0);
    step();
    chk("rst_edge", {21'd0, bus11.data_out}, 32'h000);
    chk("rst_prio_w1", {31'd0, bus1.data_out}, 32'h0);

    // release; first edge loads
    rst           = 1'b0;
    bus11.enable  = 1'b1;
    bus11.data_in = 11'h000;
    step();
    chk("load_zero", {21'd0, bus11.data_out}, 32'h000);
    chk("load_w1", {31'd0, bus1.data_out}, 32'h1);

    bus11.enable  = 1'b0;
    bus11.data_in = 11'h7FF;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_zero", {21'd0, bus11.data_out}, 32'h000);
    end

    bus11.enable = 1'b1;
    step();
    chk("load_ones", {21'd0, bus11.data_out}, 32'h7FF);

    bus11.enable  = 1'b0;
    bus11.data_in = 11'h000;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_ones", {21'd0, bus11.data_out}, 32'h7FF);
    end

    bus11.enable  = 1'b1;
    bus11.data_in = 11'h555;
    step();
    chk("load_555", {21'd0, bus11.data_out}, 32'h555);
    bus11.data_in = 11'h2AA;
    step();
    chk("load_2aa", {21'd0, bus11.data_out}, 32'h2AA);

    // async clear between edges, then reset beats an enabled edge
    #2 rst = 1'b1;
    #1;
    chk("rst_mid", {21'd0, bus11.data_out}, 32'h000);
    bus11.data_in = 11'h7FF;
    step();
    chk("rst_prio", {21'd0, bus11.data_out}, 32'h000);

    rst          = 1'b0;
    bus11.enable = 1'b0;
    step();
    chk("no_restore", {21'd0, bus11.data_out}, 32'h000);

    // input change between edges must not reach the output
    bus11.enable  = 1'b1;
    bus11.data_in = 11'h123;
    step();
    chk("load_123", {21'd0, bus11.data_out}, 32'h123);
    bus11.data_in = 11'h456;
    #2;
    chk("no_comb_path", {21'd0, bus11.data_out}, 32'h123);
    bus11.enable = 1'b0;
    #1;
    chk("no_comb_en", {21'd0, bus11.data_out}, 32'h123);
    step();
    chk("hold_123", {21'd0, bus11.data_out}, 32'h123);

    bus1.enable  = 1'b1;
    bus1.data_in = 1'b0;
    step();
    chk("load0_w1", {31'd0, bus1.data_out}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/register_11bit.md
Name: register_11bit

Overview:
- Parameterised parallel-load register with load enable; default width 11 bits.
- Each bit is a 2:1 hold/load mux feeding a D flip-flop with asynchronous reset.
- General-purpose storage element in the datapath and register-file area. It is instantiated wherever a held value with a write strobe is needed.

Parameters:
- WIDTH, 11, number of stored bits; legal range 1 and above.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset; clears all bits to 0.
- enable  input  1  load strobe. 1 = capture data_in at next rising clk edge; 0 = hold.
- data_in  input  WIDTH  value to load.
- data_out  output  WIDTH  current stored value, driven directly from the flip-flop outputs.

Behaviour:
- Reset: while rst=1, data_out = all zeros immediately, with no clock needed. It stays zero regardless of clk, enable or data_in, including when enable or data_in is X.
- Reset release: deassertion takes effect at the following rising edge. First possible load is the first rising edge with rst=0.
- Load: at a rising clk edge with rst=0 and enable=1, data_out takes data_in as sampled at that edge. Latency is 1 edge; the new value is visible after the edge.
- Hold: at a rising clk edge with rst=0 and enable=0, data_out keeps its previous value. This holds regardless of data_in changes.
- data_in changes between edges have no effect on data_out; there is no combinational path from data_in or enable to data_out.
- Simultaneous rst=1 and a rising edge with enable=1: reset wins, data_out = 0.
- Reset asserted mid-operation clears the stored value asynchronously. The old value is not restored after release.
- All bits are independent and identical; there is no cross-bit logic or arithmetic.
- Per-bit structure, required:
  - mux select = enable.
  - mux input 0 = the bit's own q (hold feedback).
  - mux input 1 = data_in bit.
  - mux output drives flip-flop d.
- No clock gating; enable acts only through the mux.

Decomposition:
- Shared package holds the constant REG_WIDTH_DEFAULT = 11. There are no typedefs.
- Natural sub-module: reg_bit_cell, one per bit via a generate loop over WIDTH.
  - Contains one 2:1 mux.
  - Contains one rising-edge D flip-flop with asynchronous active-high reset to 0.
- Top level contains only the generate loop and port wiring.

Test Plan:
- Reset with X inputs: rst=1, data_in=0, enable=X for one cycle -> data_out=0x000 throughout.
- Load zero: rst=0, enable=1, data_in=0x000, one edge -> data_out=0x000.
- Hold against input change: enable=0, data_in=0x7FF, five edges -> data_out stays 0x000.
- Load all ones, then hold: enable=1 for one edge -> data_out=0x7FF; then enable=0 and data_in=0x000 for five edges -> data_out stays 0x7FF.
- Mixed pattern and async reset: enable=1, data_in=0x555 -> 0x555. Next edge with data_in=0x2AA -> 0x2AA. Then assert rst between edges -> data_out=0x000 before the next edge.
- Reset priority and WIDTH=1 build: rst=1 together with enable=1, data_in=1 across an edge -> data_out=0. After release, enable=1, data_in=1 -> data_out=1 after one edge.
